// File: rtl/prog_sequencer.sv
// Program sequencer: arms the PC at a per-program base address, gates core
// execution, counts RUN cycles and stops the program on Halt or on watchdog expiry.
module prog_sequencer #(
    parameter int              L       = 10,
    parameter int              NPROG   = 3,
    parameter int              BASE0   = 50,
    parameter int              BASE1   = 150,
    parameter int              BASE2   = 250,
    parameter int              BASE3   = 0,
    parameter int              CW      = 16,
    parameter logic [CW-1:0]   TIMEOUT = 16'd4000
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           start_i,
    input  logic           halt_i,
    output logic           pc_load_o,
    output logic [L-1:0]   pc_target_o,
    output logic           core_en_o,
    output logic           ack_o,
    output logic [1:0]     prog_idx_o,
    output logic [CW-1:0]  cycle_cnt_o,
    output logic           timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0]    LAST_IDX = 2'(NPROG - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = TIMEOUT - CNT_ONE;

    state_e         state_q;
    logic           pc_load_q;
    logic [L-1:0]   pc_target_q;
    logic           core_en_q;
    logic           ack_q;
    logic [1:0]     prog_idx_q;
    logic [CW-1:0]  cycle_cnt_q;
    logic           timeout_q;
    logic [1:0]     next_idx_d;

    // Indices beyond NPROG fold back onto the table; base values are cut to L bits.
    function automatic logic [L-1:0] base_of(input logic [1:0] idx);
        logic [L-1:0] b;
        case (int'(idx) % NPROG)
            32'sd0:  b = L'(BASE0);
            32'sd1:  b = L'(BASE1);
            32'sd2:  b = L'(BASE2);
            32'sd3:  b = L'(BASE3);
            default: b = L'(BASE0);
        endcase
        return b;
    endfunction

    // Index of the program that the next DONE->ARMED transition will select.
    always_comb begin
        next_idx_d = 2'd0;
        if (prog_idx_q == LAST_IDX) begin
            next_idx_d = 2'd0;
        end else begin
            next_idx_d = prog_idx_q + 2'd1;
        end
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            core_en_q   <= 1'b0;
            ack_q       <= 1'b0;
            prog_idx_q  <= 2'd0;
            cycle_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= ARMED;
                        pc_load_q   <= 1'b1;
                        pc_target_q <= base_of(prog_idx_q);
                    end
                end
                ARMED: begin
                    if (start_i) begin
                        pc_load_q   <= 1'b1;
                        pc_target_q <= base_of(prog_idx_q);
                    end else begin
                        state_q     <= RUN;
                        pc_load_q   <= 1'b0;
                        core_en_q   <= 1'b1;
                        ack_q       <= 1'b0;
                        cycle_cnt_q <= '0;
                        timeout_q   <= 1'b0;
                    end
                end
                RUN: begin
                    // Halt takes priority over a watchdog expiring in the same cycle.
                    if (halt_i) begin
                        state_q   <= DONE;
                        core_en_q <= 1'b0;
                        ack_q     <= 1'b1;
                    end else if (cycle_cnt_q == CNT_MAX) begin
                        state_q   <= DONE;
                        core_en_q <= 1'b0;
                        ack_q     <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
                    end
                end
                DONE: begin
                    if (start_i) begin
                        state_q     <= ARMED;
                        prog_idx_q  <= next_idx_d;
                        ack_q       <= 1'b0;
                        pc_load_q   <= 1'b1;
                        pc_target_q <= base_of(next_idx_d);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pc_load_q <= 1'b0;
                    core_en_q <= 1'b0;
                    ack_q     <= 1'b0;
                end
            endcase
        end
    end

    assign pc_load_o   = pc_load_q;
    assign pc_target_o = pc_target_q;
    assign core_en_o   = core_en_q;
    assign ack_o       = ack_q;
    assign prog_idx_o  = prog_idx_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign timeout_o   = timeout_q;

endmodule
